// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache : direct-mapped, read-only instruction cache behind the IF stage.
//
// Ports
//   CLK       rising-edge clock
//   nRST      asynchronous active-low reset
//   imemREN   fetch request from the datapath
//   imemaddr  fetch byte address (word aligned, low two bits ignored)
//   ihit      requested word is valid on imemload this cycle
//   imemload  instruction word (0 when not hitting)
//   iREN      read request to the memory controller
//   iaddr     word-aligned memory read address
//   iwait     memory controller busy; iload valid when low while iREN high
//   iload     word returned from memory
//
// A hit is answered combinationally in IDLE. A miss latches the address,
// moves to MISS and holds the memory request until iwait drops; that cycle
// writes the frame and returns to IDLE, where the now-present word hits.
// The fill is never aborted by a redirect; only reset discards it.
// ---------------------------------------------------------------------------
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 32 - IDX - 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t             state_r;
    logic [SETS-1:0]    valid_r;
    logic [TAG_W-1:0]   tag_r  [SETS];
    logic [31:0]        data_r [SETS];
    logic [31:0]        miss_addr_r;
    logic               iren_r;
    logic [31:0]        iaddr_r;

    logic [IDX-1:0]     req_idx_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic [IDX-1:0]     miss_idx_s;
    logic [TAG_W-1:0]   miss_tag_s;
    logic               hit_s;
    logic [31:0]        load_s;

    // Byte-offset bits of the fetch address carry no information here.
    logic               unused_offset_s;
    assign unused_offset_s = ^{imemaddr[1:0], miss_addr_r[1:0]};

    // Address split for the incoming request and the latched miss.
    always_comb begin
        req_idx_s  = imemaddr[IDX+1:2];
        req_tag_s  = imemaddr[31:IDX+2];
        miss_idx_s = miss_addr_r[IDX+1:2];
        miss_tag_s = miss_addr_r[31:IDX+2];
    end

    // Zero-latency lookup: only IDLE may report a hit, so a fill cycle never
    // forwards iload straight to the datapath.
    always_comb begin
        hit_s  = 1'b0;
        load_s = 32'h0000_0000;
        if ((state_r == IDLE) && imemREN && valid_r[req_idx_s] &&
            (tag_r[req_idx_s] == req_tag_s)) begin
            hit_s  = 1'b1;
            load_s = data_r[req_idx_s];
        end else begin
            hit_s  = 1'b0;
            load_s = 32'h0000_0000;
        end
    end

    assign ihit     = hit_s;
    assign imemload = load_s;
    assign iREN     = iren_r;
    assign iaddr    = iaddr_r;

    // Miss FSM together with frame storage and the registered memory request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= IDLE;
            valid_r     <= '0;
            miss_addr_r <= 32'h0000_0000;
            iren_r      <= 1'b0;
            iaddr_r     <= 32'h0000_0000;
            for (int i = 0; i < SETS; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (imemREN && !hit_s) begin
                        miss_addr_r <= imemaddr;
                        iren_r      <= 1'b1;
                        iaddr_r     <= {imemaddr[31:2], 2'b00};
                        state_r     <= MISS;
                    end else begin
                        iren_r      <= 1'b0;
                        iaddr_r     <= 32'h0000_0000;
                        state_r     <= IDLE;
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        // Conflict misses simply overwrite the frame.
                        valid_r[miss_idx_s] <= 1'b1;
                        tag_r[miss_idx_s]   <= miss_tag_s;
                        data_r[miss_idx_s]  <= iload;
                        iren_r              <= 1'b0;
                        iaddr_r             <= 32'h0000_0000;
                        state_r             <= IDLE;
                    end else begin
                        iren_r              <= 1'b1;
                        iaddr_r             <= {miss_addr_r[31:2], 2'b00};
                        state_r             <= MISS;
                    end
                end
                default: begin
                    iren_r  <= 1'b0;
                    iaddr_r <= 32'h0000_0000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache sitting directly downstream of the pipelined datapath's IF stage.
- Consumes the fetch request (imemREN, imemaddr) and returns ihit/imemload, which the PC and IF/ID register use to advance.
- On a miss it fetches one word from the memory controller through the iREN/iaddr/iwait/iload handshake.
- Fills the frame, then serves the hit on the following cycle.

Parameters:
- SETS, 16, number of frames; power of two; index width IDX = log2(SETS).
- TAG_W, 32-IDX-2, tag width; the low 2 address bits are the byte offset and are ignored.

Ports:
- CLK  input  1  clock, rising-edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; word-aligned.
- ihit  output  1  requested word valid on imemload this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to the memory controller.
- iaddr  output  32  memory read address, word-aligned.
- iwait  input  1  memory controller busy; iload is valid in the cycle iwait is low while iREN is high.
- iload  input  32  word returned from memory.

Behaviour:
- One clock (CLK); reset nRST is asynchronous, active-low.
- Address split: tag = imemaddr[31:IDX+2], index = imemaddr[IDX+1:2].
- Storage per frame: valid (1), tag (TAG_W), data (32).
- Reset (async, immediate):
  - All valid bits clear; tag and data go to 0.
  - State goes to IDLE.
  - Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- State IDLE:
  - Hit = imemREN & valid[index] & tag[index]==tag.
  - ihit=Hit combinationally, same cycle (zero-latency hit).
  - imemload = data[index] when Hit, else 0.
  - iREN=0.
  - On imemREN & !Hit: latch imemaddr into miss_addr; next state MISS.
  - imemREN=0: ihit=0; no state change.
- State MISS:
  - ihit=0, imemload=0.
  - iREN=1, iaddr={miss_addr[31:2],2'b00}.
  - iwait=1: stay in MISS.
  - iwait=0:
    - Write the frame at miss_addr index: valid=1, tag=miss_addr tag, data=iload.
    - Next state IDLE.
  - Miss latency therefore = memory wait cycles + 1 fill cycle; the hit is asserted the cycle after the fill.
- imemaddr change or imemREN drop during MISS (e.g. branch/jump redirect, PCSrc change):
  - The fill for the latched miss_addr still completes; it is never aborted.
  - The new address is evaluated in IDLE afterwards.
- Conflict miss (same index, different tag): the frame is overwritten; no replacement choice is involved.
- No write path. Instruction memory is assumed immutable during a run; no flush or invalidate port.
- No lookahead: at most one outstanding memory request at any time.
- Reset asserted mid-MISS:
  - iREN deasserts immediately, asynchronously.
  - The in-flight fill is discarded; no frame is written.
- Hit data is never forwarded from iload in the fill cycle: ihit=0 in every MISS cycle.

Test Plan:
- Cold miss: reset, then imemREN=1, imemaddr=0x0000_0040; memory holds 0x2001_0005 with 2 wait cycles.
  - iREN=1, iaddr=0x40 for 3 cycles.
  - Then IDLE; next cycle ihit=1, imemload=0x2001_0005.
- Repeat hit: after the above, imemaddr=0x40 again.
  - ihit=1 same cycle, iREN stays 0; hit count in the bench equals request count.
- Conflict: fetch 0x40, then 0x80 (same index 0 with SETS=16, different tag), then 0x40.
  - Three misses; iaddr sequence 0x40, 0x80, 0x40.
  - Final imemload equals mem[0x40].
- Redirect mid-miss: miss on 0x100; one cycle later imemaddr changes to 0x204.
  - iaddr stays 0x100 until iwait=0.
  - Then a new miss on 0x204; after both fills, hits at both addresses.
- Reset mid-miss: assert nRST=0 during MISS with iwait=1.
  - iREN=0 immediately.
  - After release, a fetch of the same address misses again (valid bit was cleared).
- Idle: imemREN=0 with any address → ihit=0, iREN=0, imemload=0 for 10 cycles.
